// File: rtl/sigma_pkg.sv
// Shared reduction-network definitions: default VN word width, lane index width
// and the lane bit-slice convention used by the switches and the collector.
package sigma_pkg;

  localparam int unsigned DATA_TYPE_DEF = 32;

  // Width of a lane index; never narrower than one bit.
  function automatic int unsigned lane_idx_w(input int unsigned num_lanes);
    return (num_lanes > 1) ? $clog2(num_lanes) : 1;
  endfunction

  // Lane k of a packed VN bus starts at bit k*data_w.
  function automatic int unsigned lane_lsb(input int unsigned k, input int unsigned data_w);
    return k * data_w;
  endfunction

endpackage

// File: rtl/vn_lane_compactor.sv
// Combinational prefix-sum over the lane valid vector: per-lane write offset
// within the batch plus the total number of valid lanes.
module vn_lane_compactor #(
  parameter int unsigned NUM_LANES = 8,
  parameter int unsigned OFF_W     = $clog2(NUM_LANES + 1)
) (
  input  logic [NUM_LANES-1:0] valid_i,
  output logic [OFF_W-1:0]     offset_c_o [NUM_LANES],
  output logic [OFF_W-1:0]     push_cnt_c_o
);

  logic [OFF_W-1:0] acc;

  always_comb begin
    acc = '0;
    for (int k = 0; k < int'(NUM_LANES); k++) begin
      offset_c_o[k] = acc;
      acc           = acc + OFF_W'(valid_i[k]);
    end
    push_cnt_c_o = acc;
  end

endmodule

// File: rtl/vn_collector.sv
// Virtual-neuron result collector: compacts valid lanes into a FIFO with
// all-or-nothing batch acceptance. Optional tag storage via VN_COLLECTOR_TAG_EN.
module vn_collector
  import sigma_pkg::*;
#(
  parameter int unsigned DATA_TYPE = DATA_TYPE_DEF,
  parameter int unsigned NUM_SW    = 4,
  parameter int unsigned DEPTH     = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [2*DATA_TYPE*NUM_SW-1:0]         i_vn_bus,
  input  logic [2*NUM_SW-1:0]                   i_vn_valid,
  output logic [DATA_TYPE-1:0]                  o_data,
  output logic [lane_idx_w(2*NUM_SW)-1:0]       o_tag,
  output logic                                  o_valid,
  input  logic                                  i_ready,
  output logic [$clog2(DEPTH+1)-1:0]            o_count,
  output logic                                  o_almost_full,
  output logic                                  o_overflow
);

  localparam int unsigned NUM_LANES = 2 * NUM_SW;
  localparam int unsigned TAG_W     = lane_idx_w(NUM_LANES);
  localparam int unsigned PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1);
  localparam int unsigned FREE_W    = CNT_W + 1;
  localparam int unsigned OFF_W     = $clog2(NUM_LANES + 1);

  logic [DATA_TYPE-1:0] data_mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 almost_full_q, almost_full_d;

  logic [OFF_W-1:0]     offset [NUM_LANES];
  logic [OFF_W-1:0]     push_cnt;
  logic [FREE_W-1:0]    free_eff;
  logic                 pop;
  logic                 accept;

  vn_lane_compactor #(
    .NUM_LANES (NUM_LANES),
    .OFF_W     (OFF_W)
  ) u_compactor (
    .valid_i      (i_vn_valid),
    .offset_c_o   (offset),
    .push_cnt_c_o (push_cnt)
  );

  assign o_valid = (count_q != '0);
  assign pop     = o_valid & i_ready;

  // Batch acceptance and next-state pointers/flags.
  always_comb begin
    free_eff      = FREE_W'(DEPTH) - FREE_W'(count_q) + FREE_W'(pop);
    accept        = (push_cnt != '0) && (FREE_W'(push_cnt) <= free_eff);
    overflow_d    = overflow_q | ((push_cnt != '0) && !accept);
    wr_ptr_d      = wr_ptr_q + (accept ? PTR_W'(push_cnt) : PTR_W'(0));
    rd_ptr_d      = rd_ptr_q + PTR_W'(pop);
    count_d       = count_q + (accept ? CNT_W'(push_cnt) : CNT_W'(0)) - CNT_W'(pop);
    almost_full_d = (count_d > CNT_W'(DEPTH - NUM_LANES));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      almost_full_q <= almost_full_d;
    end
  end

  // Storage is cleared on reset so the head never reads X.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < int'(DEPTH); d++) data_mem_q[d] <= '0;
    end else if (accept) begin
      for (int k = 0; k < int'(NUM_LANES); k++) begin
        if (i_vn_valid[k]) begin
          data_mem_q[wr_ptr_q + PTR_W'(offset[k])] <=
            i_vn_bus[lane_lsb(k, DATA_TYPE) +: DATA_TYPE];
        end
      end
    end
  end

`ifdef VN_COLLECTOR_TAG_EN
  logic [TAG_W-1:0] tag_mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < int'(DEPTH); d++) tag_mem_q[d] <= '0;
    end else if (accept) begin
      for (int k = 0; k < int'(NUM_LANES); k++) begin
        if (i_vn_valid[k]) tag_mem_q[wr_ptr_q + PTR_W'(offset[k])] <= TAG_W'(k);
      end
    end
  end

  assign o_tag = tag_mem_q[rd_ptr_q];
`else
  assign o_tag = '0;
`endif

  assign o_data        = data_mem_q[rd_ptr_q];
  assign o_count       = count_q;
  assign o_almost_full = almost_full_q;
  assign o_overflow    = overflow_q;

endmodule

// File: tb/tb_vn_collector.sv
// Directed self-checking bench for vn_collector (NUM_SW=4, DEPTH=16).
module tb_vn_collector;

  localparam int unsigned DW    = 32;
  localparam int unsigned NL    = 8;
  localparam int unsigned DEPTH = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW*NL-1:0] vn_bus;
  logic [NL-1:0]   vn_valid;
  logic [DW-1:0]   data;
  logic [2:0]      tag;
  logic            valid;
  logic            ready;
  logic [4:0]      count;
  logic            almost_full;
  logic            overflow;

  int n_cmp = 0;
  int n_bad = 0;

  vn_collector #(.DATA_TYPE(DW), .NUM_SW(4), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_vn_bus      (vn_bus),
    .i_vn_valid    (vn_valid),
    .o_data        (data),
    .o_tag         (tag),
    .o_valid       (valid),
    .i_ready       (ready),
    .o_count       (count),
    .o_almost_full (almost_full),
    .o_overflow    (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] exp_tag(input int k);
`ifdef VN_COLLECTOR_TAG_EN
    return 3'(k);
`else
    return 3'(0 * k);
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; vn_valid = '0; ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    vn_bus   = {NL{32'hDEAD_BEEF}};
    vn_valid = '1;
    ready    = 1'b0;
    rst      = 1'b1;
    step(); step();
    n_cmp++; if (valid !== 1'b0)       begin n_bad++; $display("FAIL reset_valid got %b want 0", valid); end
    n_cmp++; if (count !== 5'd0)       begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (overflow !== 1'b0)    begin n_bad++; $display("FAIL reset_ovf got %b want 0", overflow); end
    n_cmp++; if (almost_full !== 1'b0) begin n_bad++; $display("FAIL reset_af got %b want 0", almost_full); end
    n_cmp++; if ($isunknown({data, tag})) begin n_bad++; $display("FAIL reset_data_x got %h/%h want known", data, tag); end
    rst = 1'b0; vn_valid = '0;
    step();
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL reset_nothing_stored got %0d want 0", count); end
  endtask

  task automatic test_single();
    do_reset();
    vn_bus = '0;
    vn_bus[2*DW +: DW] = 32'h3F80_0000;
    vn_valid = 8'b0000_0100;
    step();
    vn_valid = '0;
    n_cmp++; if (valid !== 1'b1)          begin n_bad++; $display("FAIL single_valid got %b want 1", valid); end
    n_cmp++; if (data !== 32'h3F80_0000)  begin n_bad++; $display("FAIL single_data got %h want 3f800000", data); end
    n_cmp++; if (tag !== exp_tag(2))      begin n_bad++; $display("FAIL single_tag got %0d want %0d", tag, exp_tag(2)); end
    n_cmp++; if (count !== 5'd1)          begin n_bad++; $display("FAIL single_count got %0d want 1", count); end
  endtask

  task automatic test_ordering();
    logic [DW-1:0] exp_d [3];
    int            exp_l [3];
    do_reset();
    exp_d[0] = 32'hAAAA_0001; exp_d[1] = 32'hBBBB_0005; exp_d[2] = 32'hCCCC_0006;
    exp_l[0] = 1; exp_l[1] = 5; exp_l[2] = 6;
    vn_bus = '0;
    vn_bus[1*DW +: DW] = exp_d[0];
    vn_bus[5*DW +: DW] = exp_d[1];
    vn_bus[6*DW +: DW] = exp_d[2];
    vn_valid = 8'b0110_0010;
    ready    = 1'b1;
    step();
    vn_valid = '0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (valid !== 1'b1 || data !== exp_d[i] || tag !== exp_tag(exp_l[i])) begin
        n_bad++; $display("FAIL order_%0d got v=%b %h/%0d want 1 %h/%0d", i, valid, data, tag, exp_d[i], exp_tag(exp_l[i]));
      end
      step();
    end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL order_empty got %b want 0", valid); end
    ready = 1'b0;
  endtask

  task automatic fill_batch(input logic [7:0] base);
    for (int k = 0; k < int'(NL); k++) vn_bus[k*DW +: DW] = {base, 24'(k)};
    vn_valid = '1;
    step();
  endtask

  task automatic test_fill_overflow();
    do_reset();
    fill_batch(8'h01);
    n_cmp++; if (count !== 5'd8 || almost_full !== 1'b0) begin n_bad++; $display("FAIL fill1 got cnt=%0d af=%b want 8/0", count, almost_full); end
    fill_batch(8'h02);
    n_cmp++; if (count !== 5'd16 || almost_full !== 1'b1) begin n_bad++; $display("FAIL fill2 got cnt=%0d af=%b want 16/1", count, almost_full); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fill2_ovf got %b want 0", overflow); end
    fill_batch(8'h03);
    n_cmp++; if (count !== 5'd16 || overflow !== 1'b1) begin n_bad++; $display("FAIL fill3 got cnt=%0d ovf=%b want 16/1", count, overflow); end
    vn_valid = '0;
    step(); step();
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    n_cmp++; if (data !== 32'h0100_0000 || tag !== exp_tag(0)) begin n_bad++; $display("FAIL fill_head got %h/%0d want 01000000/%0d", data, tag, exp_tag(0)); end
  endtask

  task automatic test_full_pop();
    do_reset();
    fill_batch(8'h01);
    fill_batch(8'h02);
    vn_bus = '0;
    vn_bus[3*DW +: DW] = 32'h0000_ABCD;
    vn_valid = 8'b0000_1000;
    ready    = 1'b1;
    step();
    vn_valid = '0; ready = 1'b0;
    n_cmp++; if (count !== 5'd16)   begin n_bad++; $display("FAIL fullpop_count got %0d want 16", count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fullpop_ovf got %b want 0", overflow); end
    n_cmp++; if (data !== 32'h0100_0001 || tag !== exp_tag(1)) begin n_bad++; $display("FAIL fullpop_head got %h/%0d want 01000001/%0d", data, tag, exp_tag(1)); end
  endtask

  task automatic test_stream();
    logic [DW-1:0] q_d [$];
    logic [2:0]    q_t [$];
    int            mdl_cnt = 0;
    int            sent    = 0;
    int            cyc     = 0;
    logic          stalled = 1'b0;
    logic [DW-1:0] prev_d  = '0;
    logic [NL-1:0] pat;
    int            pc, free;
    logic          pop;
    do_reset();
    while ((sent < 40 || mdl_cnt != 0) && cyc < 400) begin
      n_cmp++; if (count !== 5'(mdl_cnt) || valid !== (mdl_cnt != 0)) begin
        n_bad++; $display("FAIL stream_cnt cyc %0d got %0d/%b want %0d", cyc, count, valid, mdl_cnt);
      end
      if (mdl_cnt != 0) begin
        n_cmp++; if (data !== q_d[0] || tag !== q_t[0]) begin
          n_bad++; $display("FAIL stream_head cyc %0d got %h/%0d want %h/%0d", cyc, data, tag, q_d[0], q_t[0]);
        end
      end
      if (stalled) begin
        n_cmp++; if (data !== prev_d) begin n_bad++; $display("FAIL stream_stall cyc %0d got %h want %h", cyc, data, prev_d); end
      end
      ready = 1'($urandom_range(0, 1));
      pop   = (mdl_cnt != 0) && ready;
      pat   = 8'($urandom);
      pc    = $countones(pat);
      free  = int'(DEPTH) - mdl_cnt + int'(pop);
      if (sent + pc > 40 || pc > free) begin pat = '0; pc = 0; end
      vn_bus = '0;
      for (int k = 0; k < int'(NL); k++) begin
        if (pat[k]) begin
          vn_bus[k*DW +: DW] = 32'h5000_0000 + 32'(sent);
          q_d.push_back(32'h5000_0000 + 32'(sent));
          q_t.push_back(exp_tag(k));
          sent++;
        end
      end
      vn_valid = pat;
      stalled  = (mdl_cnt != 0) && !ready;
      prev_d   = data;
      step();
      if (pop) begin void'(q_d.pop_front()); void'(q_t.pop_front()); end
      mdl_cnt = mdl_cnt + pc - int'(pop);
      cyc++;
    end
    vn_valid = '0; ready = 1'b0;
    n_cmp++; if (cyc >= 400) begin n_bad++; $display("FAIL stream_timeout got %0d cycles want < 400", cyc); end
    n_cmp++; if (overflow !== 1'b0 || valid !== 1'b0) begin n_bad++; $display("FAIL stream_end got ovf=%b v=%b want 0/0", overflow, valid); end
  endtask

  initial begin
    rst = 1'b1; vn_bus = '0; vn_valid = '0; ready = 1'b0;
    test_reset();
    test_single();
    test_ordering();
    test_fill_overflow();
    test_full_pop();
    test_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
